// File: rtl/distribute_pkg.sv
// Shared definitions for the 1xN multicast distribute switch: derived widths and reset/dummy values.
package distribute_pkg;

   // When every command bit is mask, the lane still carries a 1-bit command tied to zero.
   function automatic int out_cmd_width(input int in_w, input int n);
      return (in_w > n) ? (in_w - n) : 1;
   endfunction

   function automatic int lane_idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam logic LANE_VALID_RST = 1'b0;
   localparam logic DUMMY_BIT      = 1'b0;

endpackage

// File: rtl/distribute_lane_reg.sv
// One-entry output lane register: load, drain, or hold. An empty lane always shows zero data/cmd.
module distribute_lane_reg
   import distribute_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int CMD_WIDTH  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic [CMD_WIDTH-1:0]  i_cmd,
   output logic                  o_valid,
   input  logic                  o_ready,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic [CMD_WIDTH-1:0]  o_cmd
);

   logic                  r_valid;
   logic [DATA_WIDTH-1:0] r_data;
   logic [CMD_WIDTH-1:0]  r_cmd;

   // A non-targeted lane on an accept is always free, so the drain branch already zeroes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= LANE_VALID_RST;
         r_data  <= {DATA_WIDTH{DUMMY_BIT}};
         r_cmd   <= {CMD_WIDTH{DUMMY_BIT}};
      end else if (load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
         r_cmd   <= i_cmd;
      end else if (r_valid && o_ready) begin
         r_valid <= LANE_VALID_RST;
         r_data  <= {DATA_WIDTH{DUMMY_BIT}};
         r_cmd   <= {CMD_WIDTH{DUMMY_BIT}};
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_cmd   = r_cmd;

endmodule

// File: rtl/distribute_1xn_multicast_seq.sv
// 1xN sequential multicast distribute switch with per-lane handshakes and atomic (all-lanes-free) accept.
// Optional saturating perf counters enabled by defining DISTRIBUTE_PERF_CNT_EN.
module distribute_1xn_multicast_seq
   import distribute_pkg::*;
#(
   parameter int DATA_WIDTH       = 32,
   parameter int NUM_DATA_OUT     = 4,
   parameter int IN_COMMAND_WIDTH = 6,
`ifdef DISTRIBUTE_PERF_CNT_EN
   parameter int CNT_WIDTH        = 32,
`endif
   localparam int OUT_COMMAND_WIDTH = out_cmd_width(IN_COMMAND_WIDTH, NUM_DATA_OUT)
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   i_en,
   input  logic                                   i_valid,
   output logic                                   i_ready,
   input  logic [DATA_WIDTH-1:0]                  i_data_bus,
   input  logic [IN_COMMAND_WIDTH-1:0]            i_cmd,
   output logic [NUM_DATA_OUT-1:0]                o_valid,
   input  logic [NUM_DATA_OUT-1:0]                o_ready,
   output logic [NUM_DATA_OUT*DATA_WIDTH-1:0]     o_data_bus,
`ifdef DISTRIBUTE_PERF_CNT_EN
   output logic [CNT_WIDTH-1:0]                   o_accept_cnt,
   output logic [CNT_WIDTH-1:0]                   o_stall_cnt,
   output logic [CNT_WIDTH-1:0]                   o_drop_cnt,
`endif
   output logic [NUM_DATA_OUT*OUT_COMMAND_WIDTH-1:0] o_cmd
);

   logic [NUM_DATA_OUT-1:0]      w_free;
   logic [NUM_DATA_OUT-1:0]      w_mask;
   logic [NUM_DATA_OUT-1:0]      w_load;
   logic [OUT_COMMAND_WIDTH-1:0] w_fwd_cmd;
   logic                         w_ready;
   logic                         w_accept;

   // Head-of-line blocking: any stalled lane blocks every new beat, keeping multicast atomic.
   assign w_free   = ~o_valid | o_ready;
   assign w_ready  = i_en && (&w_free);
   assign i_ready  = w_ready;
   assign w_accept = i_valid && w_ready;
   assign w_mask   = i_cmd[IN_COMMAND_WIDTH-1 -: NUM_DATA_OUT];
   assign w_load   = w_accept ? w_mask : '0;

   generate
      if (IN_COMMAND_WIDTH > NUM_DATA_OUT) begin : g_fwd
         assign w_fwd_cmd = i_cmd[OUT_COMMAND_WIDTH-1:0];
      end else begin : g_nofwd
         assign w_fwd_cmd = '0;
      end
   endgenerate

   generate
      for (genvar k = 0; k < NUM_DATA_OUT; k++) begin : g_lane
         distribute_lane_reg #(
            .DATA_WIDTH (DATA_WIDTH),
            .CMD_WIDTH  (OUT_COMMAND_WIDTH)
         ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .load    (w_load[k]),
            .i_data  (i_data_bus),
            .i_cmd   (w_fwd_cmd),
            .o_valid (o_valid[k]),
            .o_ready (o_ready[k]),
            .o_data  (o_data_bus[k*DATA_WIDTH +: DATA_WIDTH]),
            .o_cmd   (o_cmd[k*OUT_COMMAND_WIDTH +: OUT_COMMAND_WIDTH])
         );
      end
   endgenerate

`ifdef DISTRIBUTE_PERF_CNT_EN
   logic [CNT_WIDTH-1:0] r_accept_cnt;
   logic [CNT_WIDTH-1:0] r_stall_cnt;
   logic [CNT_WIDTH-1:0] r_drop_cnt;
   logic                 w_inc_accept;
   logic                 w_inc_stall;
   logic                 w_inc_drop;

   assign w_inc_accept = w_accept && (|w_mask);
   assign w_inc_drop   = w_accept && !(|w_mask);
   assign w_inc_stall  = i_valid && i_en && !w_ready;

   // Counters saturate at all-ones rather than wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_accept_cnt <= '0;
         r_stall_cnt  <= '0;
         r_drop_cnt   <= '0;
      end else begin
         if (w_inc_accept && (r_accept_cnt != '1)) r_accept_cnt <= r_accept_cnt + 1'b1;
         if (w_inc_stall  && (r_stall_cnt  != '1)) r_stall_cnt  <= r_stall_cnt  + 1'b1;
         if (w_inc_drop   && (r_drop_cnt   != '1)) r_drop_cnt   <= r_drop_cnt   + 1'b1;
      end
   end

   assign o_accept_cnt = r_accept_cnt;
   assign o_stall_cnt  = r_stall_cnt;
   assign o_drop_cnt   = r_drop_cnt;
`endif

endmodule

// File: tb/tb_distribute_1xn_multicast_seq.sv
// Self-checking bench for distribute_1xn_multicast_seq: directed scenarios plus random traffic vs. a lane-mailbox model.
module tb_distribute_1xn_multicast_seq;

   localparam int DW  = 32;
   localparam int N   = 4;
   localparam int ICW = 6;
   localparam int OCW = 2;
   localparam int CW  = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            i_en;
   logic            i_valid;
   logic            i_ready;
   logic [DW-1:0]   i_data_bus;
   logic [ICW-1:0]  i_cmd;
   logic [N-1:0]    o_valid;
   logic [N-1:0]    o_ready;
   logic [N*DW-1:0] o_data_bus;
   logic [N*OCW-1:0] o_cmd;
`ifdef DISTRIBUTE_PERF_CNT_EN
   logic [CW-1:0]   o_accept_cnt, o_stall_cnt, o_drop_cnt;
   int              m_acc, m_stall, m_drop;
`endif

   distribute_1xn_multicast_seq #(
      .DATA_WIDTH       (DW),
      .NUM_DATA_OUT     (N),
`ifdef DISTRIBUTE_PERF_CNT_EN
      .CNT_WIDTH        (CW),
`endif
      .IN_COMMAND_WIDTH (ICW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_en         (i_en),
      .i_valid      (i_valid),
      .i_ready      (i_ready),
      .i_data_bus   (i_data_bus),
      .i_cmd        (i_cmd),
      .o_valid      (o_valid),
      .o_ready      (o_ready),
      .o_data_bus   (o_data_bus),
`ifdef DISTRIBUTE_PERF_CNT_EN
      .o_accept_cnt (o_accept_cnt),
      .o_stall_cnt  (o_stall_cnt),
      .o_drop_cnt   (o_drop_cnt),
`endif
      .o_cmd        (o_cmd)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: each lane is a one-slot mailbox holding (data, cmd) or empty.
   bit           m_full [N];
   logic [DW-1:0] m_data [N];
   logic [OCW-1:0] m_cmd [N];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_ready(input logic en, input logic [N-1:0] rdy);
      bit all_free = 1'b1;
      for (int k = 0; k < N; k++)
         if (m_full[k] && !rdy[k]) all_free = 1'b0;
      return en && all_free;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < N; k++) begin
         m_full[k] = 1'b0; m_data[k] = '0; m_cmd[k] = '0;
      end
`ifdef DISTRIBUTE_PERF_CNT_EN
      m_acc = 0; m_stall = 0; m_drop = 0;
`endif
   endtask

   task automatic check_outputs(input string tag);
      logic [N-1:0]     ev;
      logic [N*DW-1:0]  ed;
      logic [N*OCW-1:0] ec;
      for (int k = 0; k < N; k++) begin
         ev[k] = m_full[k];
         ed[k*DW +: DW] = m_full[k] ? m_data[k] : '0;
         ec[k*OCW +: OCW] = m_full[k] ? m_cmd[k] : '0;
      end
      chk({tag, ".o_valid"}, 128'(o_valid), 128'(ev));
      chk({tag, ".o_data"},  128'(o_data_bus), 128'(ed));
      chk({tag, ".o_cmd"},   128'(o_cmd), 128'(ec));
`ifdef DISTRIBUTE_PERF_CNT_EN
      chk({tag, ".accept_cnt"}, 128'(o_accept_cnt), 128'(m_acc));
      chk({tag, ".stall_cnt"},  128'(o_stall_cnt),  128'(m_stall));
      chk({tag, ".drop_cnt"},   128'(o_drop_cnt),   128'(m_drop));
`endif
   endtask

   // One clock: drive after negedge, check i_ready, step the model at posedge, check outputs.
   task automatic cycle(input string tag, input logic en, input logic v, input logic [DW-1:0] d,
                        input logic [N-1:0] mask, input logic [OCW-1:0] c, input logic [N-1:0] rdy);
      logic exp_rdy;
      @(negedge clk);
      i_en = en; i_valid = v; i_data_bus = d; i_cmd = {mask, c}; o_ready = rdy;
      #1;
      exp_rdy = model_ready(en, rdy);
      chk({tag, ".i_ready"}, 128'(i_ready), 128'(exp_rdy));
      @(posedge clk);
`ifdef DISTRIBUTE_PERF_CNT_EN
      if (v && en && !exp_rdy && m_stall < 15) m_stall++;
      if (v && exp_rdy && mask != 0 && m_acc < 15) m_acc++;
      if (v && exp_rdy && mask == 0 && m_drop < 15) m_drop++;
`endif
      for (int k = 0; k < N; k++) begin
         if (m_full[k] && rdy[k]) m_full[k] = 1'b0;
         if (v && exp_rdy && mask[k]) begin
            m_full[k] = 1'b1; m_data[k] = d; m_cmd[k] = c;
         end
      end
      #1;
      check_outputs(tag);
   endtask

   initial begin
      logic [N-1:0] rmask, rrdy;
      rst = 1'b1; i_en = 1'b0; i_valid = 1'b0; i_data_bus = '0; i_cmd = '0; o_ready = '0;
      model_clear();
      #12;
      chk("reset.i_ready", 128'(i_ready), 128'(0));
      check_outputs("reset");
      @(negedge clk); rst = 1'b0;

      // Multicast to lanes 1 and 3
      cycle("mcast", 1, 1, 32'hA5A5_0001, 4'b1010, 2'b11, 4'b1111);
      chk("mcast.lane1", 128'(o_data_bus[1*DW +: DW]), 128'(32'hA5A5_0001));
      chk("mcast.lane3cmd", 128'(o_cmd[3*OCW +: OCW]), 128'(2'b11));
      cycle("mcast_drain", 1, 0, '0, 4'b0000, 2'b00, 4'b1111);

      // Backpressure on lane 2 blocks a beat aimed only at lane 0
      cycle("bp_load", 1, 1, 32'h0000_2222, 4'b0100, 2'b01, 4'b1111);
      for (int i = 0; i < 3; i++)
         cycle("bp_stall", 1, 1, 32'h0000_0BB0, 4'b0001, 2'b10, 4'b1011);
      chk("bp.lane2_held", 128'(o_data_bus[2*DW +: DW]), 128'(32'h0000_2222));
      cycle("bp_release", 1, 1, 32'h0000_0BB0, 4'b0001, 2'b10, 4'b1111);
      chk("bp.lane0", 128'(o_valid), 128'(4'b0001));
      cycle("bp_drain", 1, 0, '0, 4'b0000, 2'b00, 4'b1111);

      // Streaming 1..8 into lane 0, no bubbles
      for (int i = 1; i <= 8; i++) begin
         cycle("stream", 1, 1, DW'(i), 4'b0001, 2'(i), 4'b1111);
         chk("stream.lane0", 128'(o_data_bus[DW-1:0]), 128'(i));
      end
      cycle("stream_drain", 1, 0, '0, 4'b0000, 2'b00, 4'b1111);

      // Drop (mask 0) and disabled switch
      cycle("drop", 1, 1, 32'hDEAD_BEEF, 4'b0000, 2'b11, 4'b1111);
      chk("drop.none_valid", 128'(o_valid), 128'(0));
      for (int i = 0; i < 3; i++)
         cycle("disabled", 0, 1, 32'h1234_5678, 4'b1111, 2'b01, 4'b1111);

      // Saturate the accept counter (if present)
      for (int i = 0; i < 20; i++)
         cycle("sat", 1, 1, $urandom, 4'b0010, 2'b00, 4'b1111);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         rmask = 4'($urandom);
         rrdy  = 4'($urandom) | 4'($urandom);
         cycle("rand", ($urandom_range(0, 7) != 0), 1'($urandom), $urandom, rmask,
               2'($urandom), rrdy);
      end

      // Reset mid-traffic with lanes 1,3 held: outputs clear before any clock edge
      cycle("pre_rst", 1, 0, '0, 4'b0000, 2'b00, 4'b1111);
      cycle("pre_rst_load", 1, 1, 32'hCAFE_0013, 4'b1010, 2'b10, 4'b1111);
      cycle("pre_rst_hold", 1, 0, '0, 4'b0000, 2'b00, 4'b0000);
      chk("pre_rst.valid", 128'(o_valid), 128'(4'b1010));
      @(negedge clk); #1;
      rst = 1'b1;
      #1;
      model_clear();
      chk("midrst.o_valid", 128'(o_valid), 128'(0));
      chk("midrst.o_data", 128'(o_data_bus), 128'(0));
      check_outputs("midrst");
      @(negedge clk); rst = 1'b0;
      cycle("post_rst", 1, 1, 32'h0000_0077, 4'b1000, 2'b01, 4'b1111);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
